// File: rtl/spm_pkg.sv
// Shared types and widths for the scratchpad bank initiator.
package spm_pkg;

    localparam int unsigned SPM_ADDR_W = 9;
    localparam int unsigned SPM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } spm_init_state_t;

    // One buffered read response: the word plus its end-of-burst tag.
    typedef struct packed {
        logic [SPM_DATA_W-1:0] data;
        logic                  last;
    } spm_resp_t;

endpackage

// File: rtl/scratchpad_bank_if.sv
// Request/response wires between a bank initiator and one SRAM bank wrapper.
interface scratchpad_bank_if;
    import spm_pkg::*;

    logic                  ren;
    logic                  wen;
    logic [SPM_ADDR_W-1:0] addr;
    logic [SPM_DATA_W-1:0] wdata;
    logic [SPM_DATA_W-1:0] rdata;
    logic                  rvalid;

    modport ctrl (output ren, wen, addr, wdata, input rdata, rvalid);
    modport bank (input ren, wen, addr, wdata, output rdata, rvalid);

endinterface

// File: rtl/spm_resp_fifo.sv
// Small circular FIFO of read responses; DEPTH must be a power of two.
module spm_resp_fifo
    import spm_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  spm_resp_t                    push_data,
    input  logic                         pop,
    output spm_resp_t                    pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    spm_resp_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A push into a full FIFO means the upstream credit accounting is broken.
    assert property (@(posedge clk) disable iff (!rst) !(push && full))
        else $error("spm_resp_fifo: push while full");

endmodule

// File: rtl/spm_bank_initiator.sv
// Burst sequencer for one scratchpad bank: per-word ren/wen requests plus a
// credit-limited response FIFO that hides the bank's one-cycle read latency.
module spm_bank_initiator
    import spm_pkg::*;
#(
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [SPM_ADDR_W-1:0] cmd_addr,
    input  logic [SPM_ADDR_W-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [SPM_DATA_W-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [SPM_DATA_W-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    scratchpad_bank_if.ctrl       bank_if
);
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RESP_DEPTH);

    spm_init_state_t       state_q;
    logic [SPM_ADDR_W-1:0] cur_addr_q;
    logic [SPM_ADDR_W-1:0] beats_q;
    logic [CNT_W-1:0]      inflight_q;
    logic                  last_s1_q;
    logic                  last_s2_q;
    logic                  ren_q;
    logic                  wen_q;
    logic [SPM_ADDR_W-1:0] addr_q;
    logic [SPM_DATA_W-1:0] wdata_q;

    logic                  final_beat;
    logic                  wr_fire;
    logic                  issue;
    logic                  resp_capture;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occupancy;
    spm_resp_t             fifo_in;
    spm_resp_t             fifo_head;

    assign final_beat = (beats_q == '0);
    assign wr_fire    = (state_q == WRITE) && wr_valid;
    assign fifo_pop   = !fifo_empty && rd_ready;

    // A pop this edge frees a slot, so a new read may claim it without a bubble.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q} - {{CNT_W{1'b0}}, fifo_pop};
    assign issue     = (state_q == READ) && (occupancy < DEPTH_OCC);

    // Responses with nothing in flight are leftovers from before a reset.
    assign resp_capture = bank_if.rvalid && (inflight_q != '0);
    assign fifo_in      = '{data: bank_if.rdata, last: last_s2_q};

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE);
    assign rd_valid  = !fifo_empty;
    assign rd_data   = fifo_empty ? '0 : fifo_head.data;
    assign rd_last   = !fifo_empty && fifo_head.last;
    assign busy      = (state_q != IDLE) || !fifo_empty;

    assign bank_if.ren   = ren_q;
    assign bank_if.wen   = wen_q;
    assign bank_if.addr  = addr_q;
    assign bank_if.wdata = wdata_q;

    // Command FSM with the burst address and remaining-beat counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            beats_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr_q <= cmd_addr;
                        beats_q    <= cmd_len;
                        state_q    <= cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        cur_addr_q <= cur_addr_q + SPM_ADDR_W'(1);
                        beats_q    <= beats_q - SPM_ADDR_W'(1);
                        if (final_beat) state_q <= IDLE;
                    end
                end
                READ: begin
                    if (issue) begin
                        cur_addr_q <= cur_addr_q + SPM_ADDR_W'(1);
                        beats_q    <= beats_q - SPM_ADDR_W'(1);
                        if (final_beat) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight_q == '0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Registered bank request; address and data hold between requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ren_q <= issue;
            wen_q <= wr_fire;
            if (issue || wr_fire) addr_q  <= cur_addr_q;
            if (wr_fire)          wdata_q <= wr_data;
        end
    end

    // Outstanding-read credit and the last-beat tag riding alongside rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            last_s1_q  <= 1'b0;
            last_s2_q  <= 1'b0;
        end else begin
            case ({issue, resp_capture})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
            last_s1_q <= issue && final_beat;
            last_s2_q <= last_s1_q;
        end
    end

    spm_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_capture),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Every captured response must find a free FIFO slot.
    assert property (@(posedge clk) disable iff (!rst) !(resp_capture && fifo_full))
        else $error("spm_bank_initiator: response arrived with no FIFO room");

    assert property (@(posedge clk) disable iff (!rst) !(ren_q && wen_q))
        else $error("spm_bank_initiator: ren and wen both high");

endmodule

// File: tb/tb_spm_bank_initiator.sv
// Randomized bench for spm_bank_initiator against a word-array bank model.
module tb_spm_bank_initiator;
    import spm_pkg::*;

    localparam int unsigned RESP_DEPTH = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [8:0]  cmd_addr  = '0;
    logic [8:0]  cmd_len   = '0;
    logic        wr_valid  = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data   = '0;
    logic        rd_valid;
    logic        rd_ready  = 1'b1;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        busy;

    scratchpad_bank_if bif ();

    spm_bank_initiator #(
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .bank_if   (bif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

    logic [31:0] model_mem [512];
    logic [31:0] bank_mem  [512];
    spm_resp_t   exp_q [$];
    logic [8:0]  rd_addr_log [$];
    logic [8:0]  wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    logic [8:0]  exp_wr_addr [$];
    logic [31:0] exp_wr_data [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Bank: writes commit at the edge, reads return one cycle later; rdata is junk otherwise.
    always @(posedge clk) begin
        if (bif.wen) bank_mem[bif.addr] <= bif.wdata;
        bif.rvalid <= bif.ren;
        bif.rdata  <= bif.ren ? bank_mem[bif.addr] : $urandom;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) rd_ready = 1'($urandom_range(0, 1));
            else                 rd_ready = (ready_mode == 1);
        end
    end

    // Mid-cycle monitor: bank request log and in-order read data scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            check_eq("ren_wen_exclusive", 32'(bif.ren & bif.wen), 32'd0);
            if (bif.ren) rd_addr_log.push_back(bif.addr);
            if (bif.wen) begin
                wr_addr_log.push_back(bif.addr);
                wr_data_log.push_back(bif.wdata);
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rd_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    spm_resp_t e;
                    e = exp_q.pop_front();
                    check_eq("rd_data", rd_data, e.data);
                    check_eq("rd_last", 32'(rd_last), 32'(e.last));
                end
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [8:0] a, input logic [8:0] l);
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) check_eq("cmd_accept_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    // gap: 0 back-to-back, 1 every other cycle, 2 random
    task automatic do_write(input logic [8:0] addr, input int len, input int gap,
                            input bit fixed, input logic [31:0] base);
        int          sent;
        int          cyc;
        logic        v;
        logic        rdy;
        logic [31:0] d;
        logic [8:0]  a_i;
        sent = 0;
        cyc  = 0;
        wr_addr_log.delete();
        wr_data_log.delete();
        exp_wr_addr.delete();
        exp_wr_data.delete();
        send_cmd(1'b1, addr, 9'(len));
        d = fixed ? base : $urandom;
        while (sent <= len && cyc < 4 * len + 64) begin
            v = (gap == 0) || (gap == 1 && cyc % 2 == 0) ||
                (gap == 2 && $urandom_range(0, 1) == 1);
            wr_valid = v;
            wr_data  = d;
            @(negedge clk);
            rdy = wr_ready;
            @(posedge clk);
            #1;
            if (v && rdy) begin
                a_i = addr + 9'(sent);
                model_mem[a_i] = d;
                exp_wr_addr.push_back(a_i);
                exp_wr_data.push_back(d);
                sent++;
                d = fixed ? base + 32'(sent) : $urandom;
            end
            cyc++;
        end
        wr_valid = 1'b0;
        check_eq("wr_beats_accepted", 32'(sent), 32'(len + 1));
        repeat (2) @(posedge clk);
        #1;
        check_eq("wen_pulse_count", 32'(wr_addr_log.size()), 32'(exp_wr_addr.size()));
        for (int i = 0; i < exp_wr_addr.size() && i < wr_addr_log.size(); i++) begin
            check_eq("wen_addr", 32'(wr_addr_log[i]), 32'(exp_wr_addr[i]));
            check_eq("wen_data", wr_data_log[i], exp_wr_data[i]);
        end
    endtask

    task automatic do_read(input logic [8:0] addr, input int len, input bit chk_lat,
                           input int stall);
        int        n;
        logic [8:0] a_i;
        spm_resp_t e;
        rd_addr_log.delete();
        for (int i = 0; i <= len; i++) begin
            a_i    = addr + 9'(i);
            e.data = model_mem[a_i];
            e.last = (i == len);
            exp_q.push_back(e);
        end
        if (stall > 0) begin
            ready_mode = 0;
            @(posedge clk);
            #1;
        end
        send_cmd(1'b0, addr, 9'(len));
        if (chk_lat) begin
            n = 0;
            while (!rd_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check_eq("rd_first_latency", 32'(n), 32'd3);
        end
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            check_eq("bp_issue_count", 32'(rd_addr_log.size()), 32'(RESP_DEPTH));
            check_eq("bp_rd_valid_held", 32'(rd_valid), 32'd1);
            ready_mode = 1;
        end
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("rd_all_delivered", 32'(exp_q.size()), 32'd0);
        check_eq("ren_issue_total", 32'(rd_addr_log.size()), 32'(len + 1));
        for (int i = 0; i <= len && i < rd_addr_log.size(); i++) begin
            a_i = addr + 9'(i);
            check_eq("ren_addr", 32'(rd_addr_log[i]), 32'(a_i));
        end
    endtask

    task automatic run_random(input int count);
        logic [8:0] a;
        int         l;
        for (int t = 0; t < count; t++) begin
            a = 9'($urandom);
            l = $urandom_range(0, 20);
            ready_mode = $urandom_range(1, 2);
            if ($urandom_range(0, 1) == 1) do_write(a, l, $urandom_range(0, 2), 1'b0, 32'd0);
            else                           do_read(a, l, 1'b0, 0);
        end
        ready_mode = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("reset_ren", 32'(bif.ren), 32'd0);
        check_eq("reset_wen", 32'(bif.wen), 32'd0);
        check_eq("reset_addr", 32'(bif.addr), 32'd0);
        check_eq("reset_wdata", bif.wdata, 32'd0);
        check_eq("reset_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("reset_rd_last", 32'(rd_last), 32'd0);
        check_eq("reset_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // Fill the whole bank with a maximum-length burst.
        do_write(9'd0, 511, 0, 1'b0, 32'd0);

        do_write(9'h010, 3, 0, 1'b1, 32'hA0);
        do_read(9'h010, 3, 1'b1, 0);

        do_write(9'd510, 3, 0, 1'b0, 32'd0);
        do_read(9'd510, 3, 1'b1, 0);

        do_read(9'h040, 15, 1'b0, 10);

        do_write(9'h080, 7, 1, 1'b0, 32'd0);
        do_read(9'h080, 7, 1'b0, 0);

        // Reset while draining two outstanding reads.
        ready_mode = 1;
        send_cmd(1'b0, 9'h010, 9'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("drain_busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check_eq("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_ren", 32'(bif.ren), 32'd0);
        check_eq("midrst_rd_last", 32'(rd_last), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("postrst_no_stale_data", 32'(rd_valid), 32'd0);
        do_read(9'h011, 0, 1'b1, 0);

        run_random(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spm_bank_initiator.md
# spm_bank_initiator

Request-side sequencer for one scratchpad SRAM bank. It turns burst commands (base word address, length, direction) into per-word `ren`/`wen` requests on the bank interface. It streams write data in and read data out through valid/ready ports. A credit-limited response FIFO absorbs the bank's fixed one-cycle read latency, so downstream backpressure never loses data. It sits between the scratchpad controller/DMA and each bank wrapper.

## Interface
- `RESP_DEPTH`, default 4: response FIFO entries; power of two, at least 2; 4 or more sustains 1 word/cycle.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`/`cmd_ready`  in/out  1/1  command handshake.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  9  base word address.
- `cmd_len`  in  9  beats minus 1 (0 means 1 word, 511 means 512 words).
- `wr_valid`/`wr_ready`  in/out  1/1  write-data handshake.
- `wr_data`  in  32  write word.
- `rd_valid`/`rd_ready`  out/in  1/1  read-data handshake.
- `rd_data`  out  32  read word.
- `rd_last`  out  1  final beat of a read burst.
- `busy`  out  1  state is not IDLE, or the FIFO is non-empty.
- `bank_if`  `scratchpad_bank_if.ctrl`  drives `ren`, `wen`, `addr[8:0]`, `wdata[31:0]`; samples `rdata`, `rvalid`.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN. `cmd_ready` = (state == IDLE).
- On command accept, load the address counter (`cur_addr`) from `cmd_addr` and the beat counter from `cmd_len`.
  - Go to WRITE if `cmd_write` = 1, otherwise READ.
- WRITE:
  - `wr_ready` = 1.
  - On each `wr_valid && wr_ready`, register `wen`=1, `addr`=`cur_addr`, `wdata`=`wr_data`.
  - Then increment `cur_addr` and decrement the beat count.
  - With no handshake, `wen`=0 that cycle.
  - After the final beat is accepted, go to IDLE.
- READ:
  - Issue one read per cycle by registering `ren`=1 and `addr`=`cur_addr`, while `fifo_count + inflight < RESP_DEPTH`.
  - Otherwise register `ren`=0 (stall).
  - After the final issue, go to DRAIN.
- DRAIN: go to IDLE when `inflight` == 0.
- The `inflight` counter increments on each issue and decrements on each captured `rvalid`. Both in one cycle leaves it unchanged.
- The registered request outputs are never both high in the same cycle (`ren` & `wen`).
- A last-beat tag travels in a 2-stage shift aligned with `rvalid`. It is stored per FIFO entry and presented as `rd_last`.
- `rdata` is captured only when `rvalid` = 1. Any other value of `rdata` is ignored.
- Address arithmetic is 9-bit modulo 512; a burst wraps from 511 to 0.
- The FIFO must never overflow. A push when full is an assertion failure.
- A FIFO pop happens on `rd_valid && rd_ready`. Push and pop may occur in the same cycle.

## Timing
- Reset values:
  - State IDLE.
  - `ren`=`wen`=0, `addr`=0, `wdata`=0.
  - FIFO empty, `inflight`=0.
  - `rd_valid`=0, `rd_last`=0, `wr_ready`=0, `busy`=0.
  - `cmd_ready`=1 once reset is released.
- Write timing:
  - A handshake at edge W drives the bank request during the cycle after W.
  - The bank commits it at edge W+1.
- Read timing, uncontended:
  - Command accepted at edge E.
  - `ren` asserted after E+1.
  - Bank `rvalid` after E+2.
  - Pushed at E+3, so `rd_valid` after E+3.
  - Command-to-first-data latency is 3 cycles; then 1 word/cycle.
- The next command is accepted the cycle after returning to IDLE. Write-then-read to the same address returns the new data.
- Reset asserted mid-burst:
  - All outputs take their reset values immediately (asynchronously).
  - FIFO and counters clear; in-flight bank responses are discarded.

## Structure
- Package `spm_pkg`:
  - `SPM_ADDR_W`=9, `SPM_DATA_W`=32.
  - `spm_init_state_t` enum (IDLE/WRITE/READ/DRAIN).
  - `spm_resp_t` struct {data, last}.
- Sub-module `spm_resp_fifo`:
  - Parameterized depth, holding `spm_resp_t`.
  - Ports for push, pop, full, empty, count.
  - Same `clk` and asynchronous active-low `rst`.
- The top level holds the FSM, the address and beat counters, the `inflight` counter, the last-tag shift, and the registered bank outputs.

## Test plan
- Reset check: hold `rst`=0, then release. Required: `ren`=`wen`=0, `rd_valid`=0, `busy`=0, `cmd_ready`=1.
- Write then read back:
  - Write addr 0x010, len 3, data 0xA0..0xA3, then read the same range with `rd_ready`=1.
  - Required: `rd_data` 0xA0,0xA1,0xA2,0xA3, with `rd_last` only on 0xA3.
  - Required: first `rd_valid` 3 cycles after the read command is accepted.
- Wraparound:
  - Write addr 510, len 3, then read the same range.
  - Required: bank `addr` sequence 510, 511, 0, 1; data returned in order.
- Backpressure:
  - Read len 15 with `rd_ready`=0 for 10 cycles.
  - Required: `ren` stops after exactly `RESP_DEPTH` (4) issues.
  - Required: no FIFO overflow; all 16 words delivered in order once `rd_ready`=1.
- Write gaps: toggle `wr_valid` every other cycle on an 8-beat write. Required: `wen` pulses only on accepted beats, with contiguous addresses.
- Reset mid-read:
  - Assert `rst` during DRAIN with 2 reads in flight.
  - Required: `rd_valid`=0 immediately and the FIFO empty.
  - Required: a subsequent 1-word read returns correct data.
